// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module  : sram_port_arbiter
// Purpose : Shares a 1RW1R 32x256 SRAM macro between a byte-wide core port
//           (fixed priority) and a Wishbone host port with bounded wait.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W+1:0] i_core_waddr,
    input  logic [7:0]        i_core_wdata,
    input  logic              i_core_wen,
    input  logic [ADDR_W+1:0] i_core_raddr,
    input  logic              i_core_ren,
    output logic [7:0]        o_core_rdata,
    input  logic [31:0]       i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_rdt,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic              o_csb0,
    output logic              o_web0,
    output logic [3:0]        o_wmask0,
    output logic [ADDR_W-1:0] o_addr0,
    output logic [31:0]       o_din0,
    output logic              o_csb1,
    output logic [ADDR_W-1:0] o_addr1,
    input  logic [31:0]       i_dout1,
    output logic [CNT_W-1:0]  o_conflicts
);

    localparam int              C_TO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_TO_W-1:0]   r_to_cnt;
    logic [C_TO_W-1:0]   w_to_cnt_nxt;
    logic                r_ack;
    logic                r_err;
    logic                w_ack_nxt;
    logic                w_err_nxt;
    logic [31:0]         r_rdt;
    logic [1:0]          r_bsel;
    logic [CNT_W-1:0]    r_conf;

    logic w_host_wr;
    logic w_host_rd;
    logic w_wr_go;
    logic w_rd_go;
    logic w_blocked;
    logic w_csb0;
    logic w_web0;
    logic w_csb1;
    logic w_unused;

    assign w_host_wr = (r_state == S_IDLE) && i_wb_stb &&  i_wb_we;
    assign w_host_rd = (r_state == S_IDLE) && i_wb_stb && !i_wb_we;
    assign w_wr_go   = w_host_wr && !i_core_wen;
    assign w_rd_go   = w_host_rd && !i_core_ren;
    assign w_blocked = (w_host_wr && i_core_wen) || (w_host_rd && i_core_ren);

    // Core always wins port 0; the host only fills cycles the core leaves idle.
    always_comb begin
        w_csb0   = 1'b1;
        w_web0   = 1'b1;
        o_wmask0 = 4'h0;
        o_addr0  = '0;
        o_din0   = 32'h0;
        if (i_core_wen) begin
            w_csb0   = 1'b0;
            w_web0   = 1'b0;
            o_wmask0 = 4'b0001 << i_core_waddr[1:0];
            o_addr0  = i_core_waddr[ADDR_W+1:2];
            o_din0   = {4{i_core_wdata}};
        end else if (w_wr_go) begin
            w_csb0   = 1'b0;
            w_web0   = 1'b0;
            o_wmask0 = i_wb_sel;
            o_addr0  = i_wb_adr[ADDR_W+1:2];
            o_din0   = i_wb_dat;
        end
    end

    always_comb begin
        w_csb1  = 1'b1;
        o_addr1 = '0;
        if (i_core_ren) begin
            w_csb1  = 1'b0;
            o_addr1 = i_core_raddr[ADDR_W+1:2];
        end else if (w_rd_go) begin
            w_csb1  = 1'b0;
            o_addr1 = i_wb_adr[ADDR_W+1:2];
        end
    end

    assign o_csb0 = w_csb0 | i_rst;
    assign o_web0 = w_web0 | i_rst;
    assign o_csb1 = w_csb1 | i_rst;

    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = '0;
        w_ack_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_go) begin
                    w_state_nxt = S_RESP;
                    w_ack_nxt   = 1'b1;
                end else if (w_rd_go) begin
                    w_state_nxt = S_RD_WAIT;
                end else if (w_blocked) begin
                    if (r_to_cnt == C_TO_LAST) begin
                        w_state_nxt = S_RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                w_state_nxt = S_RESP;
                w_ack_nxt   = 1'b1;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdt    <= 32'h0;
            r_bsel   <= 2'b00;
            r_conf   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            r_ack    <= w_ack_nxt;
            r_err    <= w_err_nxt;
            // Safe to capture unconditionally: the core did not read last cycle.
            if (r_state == S_RD_WAIT) begin
                r_rdt <= i_dout1;
            end
            if (i_core_ren) begin
                r_bsel <= i_core_raddr[1:0];
            end
            if (w_blocked && (r_conf != {CNT_W{1'b1}})) begin
                r_conf <= r_conf + 1'b1;
            end
        end
    end

    assign o_core_rdata = i_dout1[{r_bsel, 3'b000} +: 8];
    assign o_wb_rdt     = r_rdt;
    assign o_wb_ack     = r_ack;
    assign o_wb_err     = r_err;
    assign o_conflicts  = r_conf;

    assign w_unused = ^{i_wb_adr[31:ADDR_W+2], i_wb_adr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module  : tb_sram_port_arbiter
// Purpose : Directed plus randomized checks of sram_port_arbiter against a
//           word-array reference of the macro and a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;
    localparam int C_CONF_MAX = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic [ADDR_W+1:0] i_core_waddr = '0;
    logic [7:0]        i_core_wdata = '0;
    logic              i_core_wen = 1'b0;
    logic [ADDR_W+1:0] i_core_raddr = '0;
    logic              i_core_ren = 1'b0;
    logic [7:0]        o_core_rdata;
    logic [31:0]       i_wb_adr = '0;
    logic [31:0]       i_wb_dat = '0;
    logic [3:0]        i_wb_sel = '0;
    logic              i_wb_we = 1'b0;
    logic              i_wb_stb = 1'b0;
    logic [31:0]       o_wb_rdt;
    logic              o_wb_ack;
    logic              o_wb_err;
    logic              o_csb0;
    logic              o_web0;
    logic [3:0]        o_wmask0;
    logic [ADDR_W-1:0] o_addr0;
    logic [31:0]       o_din0;
    logic              o_csb1;
    logic [ADDR_W-1:0] o_addr1;
    logic [31:0]       i_dout1;
    logic [CNT_W-1:0]  o_conflicts;

    sram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_core_waddr(i_core_waddr),
        .i_core_wdata(i_core_wdata),
        .i_core_wen  (i_core_wen),
        .i_core_raddr(i_core_raddr),
        .i_core_ren  (i_core_ren),
        .o_core_rdata(o_core_rdata),
        .i_wb_adr    (i_wb_adr),
        .i_wb_dat    (i_wb_dat),
        .i_wb_sel    (i_wb_sel),
        .i_wb_we     (i_wb_we),
        .i_wb_stb    (i_wb_stb),
        .o_wb_rdt    (o_wb_rdt),
        .o_wb_ack    (o_wb_ack),
        .o_wb_err    (o_wb_err),
        .o_csb0      (o_csb0),
        .o_web0      (o_web0),
        .o_wmask0    (o_wmask0),
        .o_addr0     (o_addr0),
        .o_din0      (o_din0),
        .o_csb1      (o_csb1),
        .o_addr1     (o_addr1),
        .i_dout1     (i_dout1),
        .o_conflicts (o_conflicts)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural 1RW1R macro: synchronous write, 1-cycle registered read.
    logic [31:0] mac_mem [256];
    logic        tb_init = 1'b1;
    always @(posedge i_clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mac_mem[i] <= 32'h0;
        end else begin
            if (!o_csb0 && !o_web0)
                for (int b = 0; b < 4; b++)
                    if (o_wmask0[b]) mac_mem[o_addr0][b*8 +: 8] <= o_din0[b*8 +: 8];
            if (!o_csb1) i_dout1 <= mac_mem[o_addr1];
        end
    end

    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem [256];
    int          exp_conf = 0;
    logic [31:0] exp_rdt = 32'h0;
    bit          core_pend = 1'b0;
    bit          core_pend_nx = 1'b0;
    logic [7:0]  core_exp = '0;
    logic [7:0]  core_exp_nx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        core_pend    = core_pend_nx;
        core_exp     = core_exp_nx;
        core_pend_nx = 1'b0;
    endtask

    task automatic settle();
        #2;
        if (core_pend) chk("core_rdata", {24'h0, o_core_rdata}, {24'h0, core_exp});
    endtask

    task automatic idle_core();
        i_core_wen = 1'b0;
        i_core_ren = 1'b0;
    endtask

    task automatic core_rd(input logic [ADDR_W+1:0] a);
        logic [31:0] w;
        w            = ref_mem[a[ADDR_W+1:2]];
        i_core_ren   = 1'b1;
        i_core_raddr = a;
        core_pend_nx = 1'b1;
        core_exp_nx  = w[{a[1:0], 3'b000} +: 8];
    endtask

    task automatic core_wr(input logic [ADDR_W+1:0] a, input logic [7:0] d);
        logic [31:0] w;
        i_core_wen   = 1'b1;
        i_core_waddr = a;
        i_core_wdata = d;
        w = ref_mem[a[ADDR_W+1:2]];
        w[{a[1:0], 3'b000} +: 8] = d;
        ref_mem[a[ADDR_W+1:2]] = w;
    endtask

    task automatic chk_conf();
        chk("conflicts", {16'h0, o_conflicts},
            32'((exp_conf > C_CONF_MAX) ? C_CONF_MAX : exp_conf));
    endtask

    // One host transaction with k cycles of core contention on its port.
    task automatic host_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int k,
                            input bit oth_en, input logic [ADDR_W+1:0] oth_addr);
        int          nblk;
        logic [7:0]  idx;
        logic [31:0] expv;
        logic [31:0] w;
        logic [ADDR_W+1:0] ca;
        logic [7:0]  cd;
        nblk = (k >= TIMEOUT) ? TIMEOUT : k;
        idx  = adr[ADDR_W+1:2];
        tick();
        idle_core();
        i_wb_stb = 1'b1; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        for (int c = 0; c < nblk; c++) begin
            ca = (ADDR_W+2)'($urandom);
            cd = 8'($urandom);
            if (we) core_wr(ca, cd); else core_rd(ca);
            settle();
            chk("blk_ack", {31'h0, o_wb_ack}, 32'h0);
            chk("blk_err", {31'h0, o_wb_err}, 32'h0);
            if (we) begin
                chk("blk_din0", o_din0, {4{cd}});
                chk("blk_wmask0", {28'h0, o_wmask0}, {28'h0, 4'b0001 << ca[1:0]});
            end else begin
                chk("blk_addr1", {24'h0, o_addr1}, {24'h0, ca[ADDR_W+1:2]});
            end
            tick();
        end
        exp_conf += nblk;
        idle_core();
        if (k >= TIMEOUT) begin
            i_wb_stb = 1'b0;
            settle();
            chk("tmo_err", {31'h0, o_wb_err}, 32'h1);
            chk("tmo_ack", {31'h0, o_wb_ack}, 32'h0);
            chk("tmo_rdt", o_wb_rdt, exp_rdt);
            chk("tmo_csb0", {31'h0, o_csb0}, 32'h1);
            tick();
            settle();
            chk("tmo_err_clr", {31'h0, o_wb_err}, 32'h0);
            chk("tmo_ack_clr", {31'h0, o_wb_ack}, 32'h0);
        end else if (we) begin
            if (oth_en) core_rd(oth_addr);
            settle();
            chk("wr_csb0", {31'h0, o_csb0}, 32'h0);
            chk("wr_web0", {31'h0, o_web0}, 32'h0);
            chk("wr_addr0", {24'h0, o_addr0}, {24'h0, idx});
            chk("wr_wmask0", {28'h0, o_wmask0}, {28'h0, sel});
            chk("wr_din0", o_din0, dat);
            chk("wr_ack_early", {31'h0, o_wb_ack}, 32'h0);
            if (oth_en) chk("wr_core_addr1", {24'h0, o_addr1}, {24'h0, oth_addr[ADDR_W+1:2]});
            w = ref_mem[idx];
            for (int b = 0; b < 4; b++) if (sel[b]) w[b*8 +: 8] = dat[b*8 +: 8];
            ref_mem[idx] = w;
            tick();
            i_wb_stb = 1'b0;
            idle_core();
            settle();
            chk("wr_ack", {31'h0, o_wb_ack}, 32'h1);
            chk("wr_err", {31'h0, o_wb_err}, 32'h0);
        end else begin
            expv = ref_mem[idx];
            if (oth_en) core_wr(oth_addr, 8'($urandom));
            settle();
            chk("rd_csb1", {31'h0, o_csb1}, 32'h0);
            chk("rd_addr1", {24'h0, o_addr1}, {24'h0, idx});
            if (oth_en) chk("rd_core_csb0", {31'h0, o_csb0}, 32'h0);
            tick();
            i_wb_stb = 1'b0;
            idle_core();
            settle();
            chk("rd_ack_early", {31'h0, o_wb_ack}, 32'h0);
            tick();
            settle();
            chk("rd_ack", {31'h0, o_wb_ack}, 32'h1);
            chk("rd_err", {31'h0, o_wb_err}, 32'h0);
            chk("rd_rdt", o_wb_rdt, expv);
            exp_rdt = expv;
        end
        if (k < TIMEOUT) begin
            tick();
            settle();
            chk("resp_done", {31'h0, o_wb_ack}, 32'h0);
        end
        chk_conf();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit    we;
        int    k;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        // Reset with both core requests active: chip selects must stay off.
        #1 i_rst = 1'b1;
        i_core_wen = 1'b1;
        i_core_ren = 1'b1;
        tick();
        settle();
        chk("rst_csb0", {31'h0, o_csb0}, 32'h1);
        chk("rst_web0", {31'h0, o_web0}, 32'h1);
        chk("rst_csb1", {31'h0, o_csb1}, 32'h1);
        chk("rst_ack", {31'h0, o_wb_ack}, 32'h0);
        chk("rst_err", {31'h0, o_wb_err}, 32'h0);
        chk("rst_rdt", o_wb_rdt, 32'h0);
        chk_conf();
        tick();
        i_rst   = 1'b0;
        tb_init = 1'b0;
        idle_core();

        host_txn(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 0, 1'b0, '0);
        host_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, '0);
        host_txn(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 0, 1'b1, 10'h013);
        host_txn(1'b1, 32'h24, 32'h1122_3344, 4'h5, 3, 1'b0, '0);
        host_txn(1'b1, 32'h28, 32'hDEAD_BEEF, 4'hF, TIMEOUT, 1'b0, '0);

        // Host gives up mid-wait, then a wait of TIMEOUT-1 must still be granted.
        tick();
        i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = 32'h30; i_wb_sel = 4'hF;
        for (int c = 0; c < 5; c++) begin
            core_wr(10'($urandom), 8'($urandom));
            tick();
        end
        exp_conf += 5;
        idle_core();
        i_wb_stb = 1'b0;
        settle();
        chk("drop_csb0", {31'h0, o_csb0}, 32'h1);
        chk("drop_ack", {31'h0, o_wb_ack}, 32'h0);
        host_txn(1'b1, 32'h30, 32'h5555_AAAA, 4'hF, TIMEOUT - 1, 1'b0, '0);

        // Reset while in RD_WAIT.
        tick();
        idle_core();
        i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h10;
        tick();
        i_wb_stb = 1'b0;
        #1 i_rst = 1'b1;
        #1;
        chk("arst_ack", {31'h0, o_wb_ack}, 32'h0);
        chk("arst_rdt", o_wb_rdt, 32'h0);
        chk("arst_csb1", {31'h0, o_csb1}, 32'h1);
        exp_conf = 0;
        exp_rdt  = 32'h0;
        chk_conf();
        tick();
        i_rst = 1'b0;
        settle();
        chk("arst_noack1", {31'h0, o_wb_ack}, 32'h0);
        tick();
        settle();
        chk("arst_noack2", {31'h0, o_wb_ack}, 32'h0);
        host_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, '0);

        // Randomized transactions with contention, aliasing and concurrency.
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom);
            k  = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 4));
            host_txn(we, $urandom, $urandom, 4'($urandom), k,
                     1'($urandom), (ADDR_W+2)'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sits between the subservient core's byte-wide SRAM interface, the Wishbone debug/host port, and the sky130 1RW1R 32x256 SRAM macro.
- Shares the macro's write port (port 0) and read port (port 1) between the two requesters.
- The core has fixed-latency priority. The host is granted a port only on cycles when the core leaves that port idle.
- A bounded-wait timeout with an error response prevents the host from hanging forever.

Parameters:
- ADDR_W, 8, word address width of the macro (256 x 32-bit words).
- TIMEOUT, 64, cycles a host request may wait for its port before being terminated with o_wb_err.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- i_clk  in  1  clock for the arbiter and both macro ports
- i_rst  in  1  asynchronous, active-high reset
- i_core_waddr  in  ADDR_W+2  core byte write address
- i_core_wdata  in  8  core write byte
- i_core_wen  in  1  core write request, single cycle
- i_core_raddr  in  ADDR_W+2  core byte read address
- i_core_ren  in  1  core read request, single cycle
- o_core_rdata  out  8  core read byte, valid the cycle after i_core_ren
- i_wb_adr  in  32  host byte address; bits [ADDR_W+1:2] are used
- i_wb_dat  in  32  host write data
- i_wb_sel  in  4  host byte enables
- i_wb_we  in  1  host write
- i_wb_stb  in  1  host strobe (cyc is folded in)
- o_wb_rdt  out  32  host read data
- o_wb_ack  out  1  host acknowledge
- o_wb_err  out  1  host timeout error
- o_csb0  out  1  macro port 0 chip select, active low
- o_web0  out  1  macro port 0 write enable, active low
- o_wmask0  out  4  macro port 0 byte mask
- o_addr0  out  ADDR_W  macro port 0 address
- o_din0  out  32  macro port 0 write data
- o_csb1  out  1  macro port 1 chip select, active low
- o_addr1  out  ADDR_W  macro port 1 address
- i_dout1  in  32  macro port 1 read data (1-cycle latency)
- o_conflicts  out  CNT_W  saturating count of host-wait cycles

Behaviour:
- Reset (asynchronous, i_rst high):
  - State is IDLE.
  - o_wb_ack=0, o_wb_err=0, o_wb_rdt=0, o_conflicts=0.
  - Timeout counter=0, registered core byte-select=0.
  - o_csb0=o_csb1=1 and o_web0=1 while i_rst is high, regardless of requesters.
- Core write:
  - When i_core_wen is set, port 0 is driven combinationally in the same cycle.
  - csb0=0, web0=0, wmask0=1<<waddr[1:0], addr0=waddr[ADDR_W+1:2], din0={4{wdata}}.
- Core read:
  - When i_core_ren is set, port 1 is driven the same cycle: csb1=0, addr1=raddr[ADDR_W+1:2].
  - raddr[1:0] is registered.
  - Next cycle, o_core_rdata = i_dout1[bsel*8 +: 8].
  - Between reads, o_core_rdata follows i_dout1 with the last registered bsel.
- Idle ports: csb0=1, web0=1, csb1=1; wmask0, addr0, din0 and addr1 are don't-care but stable.
- Host FSM states: IDLE, RD_WAIT, RESP.
- IDLE, host write (stb & we):
  - If i_core_wen=0, drive port 0 that cycle: wmask0=i_wb_sel, din0=i_wb_dat, addr0 from i_wb_adr.
  - Go to RESP with ack pending.
- IDLE, host read (stb & !we):
  - If i_core_ren=0, drive port 1 that cycle and go to RD_WAIT.
- RD_WAIT: capture i_dout1 into o_wb_rdt, go to RESP. The core cannot own dout1 in this cycle because it did not read in the issue cycle.
- RESP:
  - o_wb_ack=1 for exactly one cycle, then return to IDLE.
  - No new request is accepted in RESP.
  - Host write ack latency is 1 cycle; host read ack latency is 2 cycles after issue.
- Blocked host request (stb held, port busy with core):
  - Stay in IDLE, increment the timeout counter, and increment o_conflicts (saturating at all-ones).
  - If the counter reaches TIMEOUT-1 while still blocked, go to RESP with o_wb_err=1 and o_wb_ack=0 for one cycle. No SRAM access is made and o_wb_rdt is unchanged.
  - The counter clears on grant or on error.
- Concurrency:
  - A host write and a core read may run in the same cycle (different ports).
  - A host read and a core write may also run in the same cycle.
- Host stb dropped mid-wait: the counter clears and no access is made.
- Host stb dropped in RD_WAIT or RESP: the response still completes.
- Reset mid-operation: the FSM returns to IDLE immediately, and any pending ack or err is discarded.
- Address wrap: host and core addresses above 4*2^ADDR_W bytes alias modulo the macro size; upper bits are ignored.

Test Plan:
- Host write adr=0x10, dat=0xA5A5_1234, sel=0xF, core idle -> cycle 0: csb0=0, addr0=4, wmask0=0xF; ack at cycle 1; o_conflicts=0.
- Host read adr=0x10 after the previous write, with the model returning 0xA5A5_1234 -> csb1=0, addr1=4 at cycle 0; ack with o_wb_rdt=0xA5A5_1234 at cycle 2.
- Core read raddr=0x13 while the host writes adr=0x20 in the same cycle -> both ports active; o_core_rdata=dout1[31:24] the next cycle; host ack at cycle 1.
- Core asserts wen for 3 consecutive cycles while a host write is pending -> host issues on cycle 3 and acks on cycle 4; o_conflicts=3.
- Core wen held for TIMEOUT cycles with the host write pending -> o_wb_err=1 pulse at cycle TIMEOUT; csb0 never driven with host data; ack never asserted.
- Assert i_rst in RD_WAIT -> no ack; all outputs return to reset values asynchronously; the next host read completes normally.
